// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the 32-bit ALU and the multiply
//                sequencer: ALU_control codes, bonus_control codes and the
//                sequencer FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // ALU_control operation codes
  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;
  localparam logic [3:0] ALU_CTRL_NAND = 4'b1101;

  // bonus_control codes: refine the compare performed under ALU_CTRL_SLT
  localparam logic [2:0] ALU_BONUS_NONE = 3'b000;
  localparam logic [2:0] ALU_BONUS_SGT  = 3'b001;
  localparam logic [2:0] ALU_BONUS_SLE  = 3'b010;
  localparam logic [2:0] ALU_BONUS_SGE  = 3'b011;
  localparam logic [2:0] ALU_BONUS_SEQ  = 3'b100;
  localparam logic [2:0] ALU_BONUS_SNE  = 3'b101;

  // Multiply sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
//  Module      : alu
//  Description : 32-bit combinational ALU (AND/OR/ADD/SUB/SLT/NOR/NAND with
//                bonus compare variants). Outputs are forced to zero while
//                rst_n is low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
  import alu_pkg::*;
(
  input  logic        rst_n,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ALU_control,
  input  logic [2:0]  bonus_control,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);

  logic [32:0] sum_w;
  logic [32:0] diff_w;
  logic        lt_w;
  logic        eq_w;
  logic        cmp_w;

  assign sum_w  = {1'b0, src1} + {1'b0, src2};
  assign diff_w = {1'b0, src1} + {1'b0, ~src2} + 33'd1;
  assign lt_w   = $signed(src1) < $signed(src2);
  assign eq_w   = (src1 == src2);

  // Compare flavour selected by bonus_control
  always_comb begin
    cmp_w = lt_w;
    case (bonus_control)
      ALU_BONUS_SGT: cmp_w = ~lt_w & ~eq_w;
      ALU_BONUS_SLE: cmp_w = lt_w | eq_w;
      ALU_BONUS_SGE: cmp_w = ~lt_w;
      ALU_BONUS_SEQ: cmp_w = eq_w;
      ALU_BONUS_SNE: cmp_w = ~eq_w;
      default:       cmp_w = lt_w;
    endcase
  end

  // Operation decode; everything reads as zero while held in reset
  always_comb begin
    result   = 32'd0;
    cout     = 1'b0;
    overflow = 1'b0;
    if (rst_n) begin
      case (ALU_control)
        ALU_CTRL_AND:  result = src1 & src2;
        ALU_CTRL_OR:   result = src1 | src2;
        ALU_CTRL_ADD: begin
          result   = sum_w[31:0];
          cout     = sum_w[32];
          overflow = (src1[31] == src2[31]) && (sum_w[31] != src1[31]);
        end
        ALU_CTRL_SUB: begin
          result   = diff_w[31:0];
          cout     = diff_w[32];
          overflow = (src1[31] != src2[31]) && (diff_w[31] != src1[31]);
        end
        ALU_CTRL_SLT:  result = {31'd0, cmp_w};
        ALU_CTRL_NOR:  result = ~(src1 | src2);
        ALU_CTRL_NAND: result = ~(src1 & src2);
        default:       result = 32'd0;
      endcase
    end
  end

  assign zero = (result == 32'd0);

endmodule

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Unsigned 32x32->64 shift-add multiplier that borrows an
//                external combinational ALU for one add per cycle.
//                IDLE accepts a request, RUN performs 32 add/shift steps,
//                DONE holds the product until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*XLEN-1:0]   out_prod,
  output logic                alu_rst_n,
  output logic [XLEN-1:0]     alu_src1,
  output logic [XLEN-1:0]     alu_src2,
  output logic [3:0]          alu_ctrl,
  output logic [2:0]          alu_bonus,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_cout
);

  localparam logic [4:0] LAST_ITER = 5'd31;

  mul_state_t      state_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [XLEN-1:0] hi_q,    hi_d;
  logic [XLEN-1:0] lo_q,    lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [4:0]      cnt_q,   cnt_d;

  // Datapath next-state: load on accept, 65-bit right shift of {cout,sum,lo} in RUN
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    if (!flush) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_d = in_a;
            lo_d    = in_b;
            hi_d    = '0;
            cnt_d   = 5'd0;
          end
        end
        S_RUN: begin
          hi_d  = {alu_cout, alu_result[XLEN-1:1]};
          lo_d  = {alu_result[0], lo_q[XLEN-1:1]};
          cnt_d = (cnt_q == LAST_ITER) ? 5'd0 : cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; a flush leaves them as they are, reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= 5'd0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control FSM with registered handshake outputs; flush beats any handshake
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_q == LAST_ITER) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ALU operands come only from registered state; idle operands are zero
  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    if (state_q == S_RUN) begin
      alu_src1 = hi_q;
      alu_src2 = lo_q[0] ? mcand_q : '0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = {hi_q, lo_q};
  assign alu_rst_n = ~rst;
  assign alu_ctrl  = ALU_CTRL_ADD;
  assign alu_bonus = ALU_BONUS_NONE;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Self-checking bench for alu_mul_seq wired to the real alu.
//                Table vectors, hand-written handshake/abort sequences and a
//                random run, all scored against a 64-bit reference multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_prod;
  logic        alu_rst_n;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic        alu_cout, alu_zero, alu_ovf;

  always #5 clk = ~clk;

  alu_mul_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  alu u_alu (
    .rst_n(alu_rst_n), .src1(alu_src1), .src2(alu_src2),
    .ALU_control(alu_ctrl), .bonus_control(alu_bonus),
    .result(alu_result), .zero(alu_zero), .cout(alu_cout), .overflow(alu_ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl[7];
  logic [63:0] sb_q[$];
  int          nvec  = 0;
  int          nmiss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    return ea * eb;
  endfunction

  // Present a request and return just after the edge that accepts it
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the product, optionally stall, then take it and score it
  task automatic collect(input int exp_lat, input int stall, input string nm);
    int          n;
    logic [63:0] exp;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_timeout"}, 64'(n), 64'd0);
      return;
    end
    if (exp_lat > 0) chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_stall_prod"}, out_prod, exp);
      chk({nm, "_stall_in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk({nm, "_prod"}, out_prod, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        seen;
    logic [63:0] hold;

    tbl[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'd0,          32'h1234_5678,  64'h0};
    tbl[3] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    tbl[4] = '{32'd1,          32'hCAFE_BABE,  64'h0000_0000_CAFE_BABE};
    tbl[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_alu_rst_n", 64'(alu_rst_n), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_prod",  out_prod,       64'd0);
    chk("rst_src1",      64'(alu_src1),  64'd0);
    chk("rst_src2",      64'(alu_src2),  64'd0);
    chk("alu_ctrl",      64'(alu_ctrl),  64'(4'b0010));
    chk("alu_bonus",     64'(alu_bonus), 64'd0);
    chk("alu_rst_n",     64'(alu_rst_n), 64'd1);

    // Table vectors with latency check
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(tbl[i].exp);
      issue(tbl[i].a, tbl[i].b);
      collect(33, 0, $sformatf("tbl%0d", i));
    end

    // Backpressure, then a second request presented with out_ready
    sb_q.push_back(ref_mul(32'h0000_ABCD, 32'h0001_2345));
    issue(32'h0000_ABCD, 32'h0001_2345);
    collect(33, 10, "bp");
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    sb_q.push_back(ref_mul(32'h7654_3210, 32'h0F0F_0F0F));
    issue(32'h7654_3210, 32'h0F0F_0F0F);
    collect(33, 0, "b2b");

    // Request arriving in the same cycle DONE is left waits for IDLE
    sb_q.push_back(ref_mul(32'd7, 32'd9));
    issue(32'd7, 32'd9);
    while (!out_valid) @(negedge clk);
    hold = sb_q.pop_front();
    chk("b2b_first_prod", out_prod, hold);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'd11;
    in_b      = 32'd13;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle_ready", 64'(in_ready), 64'd1);
    chk("b2b_idle_valid", 64'(out_valid), 64'd0);
    sb_q.push_back(64'd143);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect(33, 0, "b2b_second");

    // Flush during RUN
    issue(32'h1111_1111, 32'h2222_2222);
    repeat (17) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_src1",      64'(alu_src1),  64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("flush_no_output", 64'(seen), 64'd0);

    // Flush in DONE beats out_ready
    issue(32'd5, 32'd6);
    while (!out_valid) @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_ready", 64'(in_ready),  64'd1);

    // Reset during RUN
    issue(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_run_alu_rst_n", 64'(alu_rst_n), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_run_in_ready",  64'(in_ready),  64'd1);
    chk("rst_run_out_valid", 64'(out_valid), 64'd0);
    chk("rst_run_out_prod",  out_prod,       64'd0);
    chk("rst_run_src1",      64'(alu_src1),  64'd0);
    chk("rst_run_src2",      64'(alu_src2),  64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("rst_no_output", 64'(seen), 64'd0);

    // Random pairs with random consumer stalls
    for (int r = 0; r < 1000; r++) begin
      ra = $urandom;
      rb = $urandom;
      if (r % 50 == 0) ra = 32'hFFFF_FFFF;
      if (r % 70 == 0) rb = 32'hFFFF_FFFF;
      sb_q.push_back(ref_mul(ra, rb));
      issue(ra, rb);
      collect(0, $urandom_range(0, 3), "rand");
    end

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 32×32→64 multiply sequencer built around the existing 32-bit combinational ALU. It owns the ALU's control and operand inputs for the duration of a multiply and issues one ALU add per cycle, using the ALU's `result` and `cout` to form a shift-add product. It sits between an issuing unit (valid/ready request) and a consumer (valid/ready response).

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported, matching the ALU.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: sequencer can accept a request.
- `in_a` in 32: multiplicand.
- `in_b` in 32: multiplier.
- `flush` in 1: synchronous abort. Returns to IDLE and discards any work.
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts the product.
- `out_prod` out 64: unsigned product, `{hi, lo}`.
- `alu_rst_n` out 1: drives the ALU `rst_n`. Equals `~rst`, combinational.
- `alu_src1` out 32: ALU source 1.
- `alu_src2` out 32: ALU source 2.
- `alu_ctrl` out 4: ALU_control. Constant ADD (4'b0010).
- `alu_bonus` out 3: bonus_control. Constant 3'b000.
- `alu_result` in 32: ALU result.
- `alu_cout` in 1: ALU carry out of bit 31.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load `mcand`←`in_a`, `lo`←`in_b`, `hi`←0, `cnt`←0, then go to RUN.
- **RUN (32 iterations, one per cycle)**
  - Drive `alu_src1`=`hi`.
  - Drive `alu_src2` = `lo[0]` ? `mcand` : 0.
  - At the clock edge: `{hi, lo}` ← `{alu_cout, alu_result, lo[31:1]}`. This is a 65-bit right shift of `{cout, sum, lo}` by 1.
  - `cnt` increments by one per iteration. When `cnt`==31, go to DONE.
  - `cnt` is 5 bits and never wraps inside a run.
- **DONE**
  - `out_valid`=1 and `out_prod`=`{hi, lo}`, both held stable until `out_ready`.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `in_ready`=0 in DONE. There is no same-cycle bypass of a new request.
- **ALU drive outside RUN:** `alu_src1`=`alu_src2`=0. `alu_ctrl` and `alu_bonus` are constant.
- **Ignored ALU outputs:** `zero` and `overflow` are not used.
- **Arithmetic:** all unsigned. The carry into the 65th bit is exactly `alu_cout`, with no sign handling. The result is exact modulo 2^64 (no truncation).
- **Flush**
  - In any state, returns to IDLE at the next edge.
  - `out_valid` drops at that edge, and the pending product is discarded.
  - `flush` has priority over `in_valid` and `out_ready` in the same cycle.
- **Reset**
  - Same effect as flush, plus data registers are cleared.
  - Reset mid-RUN abandons the product; no output is produced.
- **No extra decode:** `in_valid` in RUN or DONE is ignored (`in_ready`=0). The requester must hold the request.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_prod`=0, `hi`=`lo`=`mcand`=0, `cnt`=0, `alu_src1`=`alu_src2`=0.
- Latency: request accepted at edge of cycle T; `out_valid` first high in cycle T+33.
- Throughput: one multiply per 34 cycles minimum (accept, 32×RUN, DONE with immediate `out_ready`).
- The ALU is purely combinational. Operands are driven from registers, and the sum is captured in the same cycle, so there is one ALU pass per clock.
- All outputs except `alu_rst_n` are registered or decoded from registered state only. There is no input→output combinational path.

## Structure
- Shared package `alu_pkg`:
  - `ALU_CTRL_ADD`=4'b0010 and the other ALU_control codes (AND 0000, OR 0001, SUB 0110, NOR 1100, NAND 1101, SLT 0111).
  - The bonus_control codes.
  - The FSM state enum `mul_state_t`.
- One module. FSM and datapath registers are small; no sub-module is warranted.
- The bench instantiates the real `alu` and connects it to the `alu_*` ports.

## Test plan
- Basic: a=3, b=5 → `out_prod`=64'h0000_0000_0000_000F; `out_valid` rises exactly 33 cycles after accept.
- Max: a=b=32'hFFFF_FFFF → `out_prod`=64'hFFFF_FFFE_0000_0001. This exercises `alu_cout`=1 on carry iterations.
- Zero and identity: a=0, b=32'h1234_5678 → 0; a=32'h8000_0000, b=2 → 64'h0000_0001_0000_0000.
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 10 cycles in DONE: `out_prod` stays stable and `in_ready`=0 throughout.
  - Then accept, with a second request presented in the same cycle: it is accepted in the following IDLE cycle and its result is correct.
- Flush/reset mid-run:
  - Assert `flush` at RUN iteration 17: next cycle is IDLE with `in_ready`=1; no `out_valid` for the aborted op.
  - Repeat with `rst`: all outputs return to their reset values.
- Random: 1000 random (a, b) pairs with random `out_ready` stalls, each checked against a 64-bit reference multiply.
